// File: rtl/bus_mem_responder.sv
// Data-memory bus responder: single outstanding access, fixed wait states,
// local word RAM with byte-lane writes and a one-cycle registered ack.
module bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter logic [31:0] ADDR_MASK   = 32'h0000_3FFF,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ack,
    output logic [31:0] o_rdata
);

    localparam int         IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            req_we;
    logic [IW-1:0]   req_idx;
    logic [31:0]     req_wdata;
    logic [3:0]      req_be;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            hit;
    logic            start;
    logic            finish;
    logic            enter_ack;
    logic            acc_we;
    logic [IW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;

    assign hit       = (i_addr & ~ADDR_MASK) == BASE_ADDR;
    assign start     = (state == S_IDLE) && i_stb && hit;
    assign finish    = (state == S_WAIT) && i_stb && (cnt == 4'd1);
    assign enter_ack = i_rst && ((start && (WC == 4'd0)) || finish);

    // With no wait states the access happens straight from the bus inputs
    always_comb begin
        acc_we    = req_we;
        acc_idx   = req_idx;
        acc_wdata = req_wdata;
        acc_be    = req_be;
        if (state == S_IDLE) begin
            acc_we    = i_we;
            acc_idx   = i_addr[IW+1:2];
            acc_wdata = i_wdata;
            acc_be    = i_be;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state     <= S_IDLE;
            o_ack     <= 1'b0;
            o_rdata   <= 32'd0;
            cnt       <= 4'd0;
            req_we    <= 1'b0;
            req_idx   <= '0;
            req_wdata <= 32'd0;
            req_be    <= 4'd0;
        end else begin
            o_ack <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        req_we    <= i_we;
                        req_idx   <= i_addr[IW+1:2];
                        req_wdata <= i_wdata;
                        req_be    <= i_be;
                        cnt       <= WC;
                        if (WC == 4'd0) begin
                            state <= S_ACK;
                            o_ack <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!i_stb) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd1) begin
                        state <= S_ACK;
                        o_ack <= 1'b1;
                    end
                end
                S_ACK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (enter_ack && !acc_we) begin
                o_rdata <= mem[acc_idx];
            end
        end
    end

    // RAM is not reset; only enabled lanes change on a completing store
    always_ff @(posedge i_clk) begin
        if (enter_ack && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
